// File: rtl/lc3_control_unit_pkg.sv
// Shared definitions for the LC3 pipeline controller: opcodes, FSM states,
// memory-access state encodings and small opcode-class helpers.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    CTRL    = 3'd1,
    MEM_IND = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4
  } state_e;

  localparam logic [1:0] MS_RD   = 2'd0;
  localparam logic [1:0] MS_IND  = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  // Producers whose result comes out of the execute-stage ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  // Producers whose result comes back from data memory.
  function automatic logic is_load_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  // Instructions that never reach writeback: stores and control transfers.
  function automatic logic no_writeback(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI) ||
           (op == OP_BR) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/lc3_control_unit_if.sv
// Status/control bus between the pipeline agent (master) and the
// controller (slave).
interface lc3_control_unit_if;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic [15:0] IR_Exec;
  logic [15:0] IMem_dout;

  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  modport master (
    output complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );

  modport slave (
    input  complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );
endinterface

// File: rtl/lc3_bypass_unit.sv
// Operand forwarding decision: compares the execute-stage destination
// register against the decode-stage source registers.
module lc3_bypass_unit
  import lc3_ctrl_pkg::*;
(
  input  logic        enable,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic [3:0] op_d_s;
  logic [3:0] op_e_s;
  logic       sr1_hit_s;
  logic       sr2_hit_s;
  logic       unused_bits_s;

  assign op_d_s = ir[15:12];
  assign op_e_s = ir_exec[15:12];
  assign unused_bits_s = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

  // Source-register matches; SR2 only exists for register-mode ADD/AND.
  always_comb begin
    sr1_hit_s = (ir_exec[11:9] == ir[8:6]);
    if (((op_d_s == OP_ADD) || (op_d_s == OP_AND)) && (ir[5] == 1'b0)) begin
      sr2_hit_s = (ir_exec[11:9] == ir[2:0]);
    end else begin
      sr2_hit_s = 1'b0;
    end
  end

  // Route each match to the ALU or memory forwarding path by producer class.
  always_comb begin
    bypass_alu_1 = 1'b0;
    bypass_alu_2 = 1'b0;
    bypass_mem_1 = 1'b0;
    bypass_mem_2 = 1'b0;
    if (enable) begin
      bypass_alu_1 = is_alu_op(op_e_s)  & sr1_hit_s;
      bypass_alu_2 = is_alu_op(op_e_s)  & sr2_hit_s;
      bypass_mem_1 = is_load_op(op_e_s) & sr1_hit_s;
      bypass_mem_2 = is_load_op(op_e_s) & sr2_hit_s;
    end else begin
      bypass_alu_1 = 1'b0;
      bypass_alu_2 = 1'b0;
      bypass_mem_1 = 1'b0;
      bypass_mem_2 = 1'b0;
    end
  end

endmodule

// File: rtl/lc3_control_unit.sv
// LC3 pipeline controller: stage valid tracking, memory-access stalls,
// control-transfer bubbles, branch decision and operand forwarding.
module lc3_control_unit
  import lc3_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  lc3_control_unit_if.slave  bus
);

  state_e     state_r;
  state_e     state_nxt_s;
  logic       f_v_r, d_v_r, e_v_r, w_v_r;
  logic       f_v_nxt_s, d_v_nxt_s, e_v_nxt_s, w_v_nxt_s;
  logic [4:0] en_nxt_s;   // {updatePC, fetch, decode, execute, writeback}
  logic [1:0] ms_nxt_s;
  logic [4:0] en_r;
  logic [1:0] mem_state_r;
  logic       br_taken_s;
  logic [3:0] op_d_s;
  logic [3:0] op_e_s;
  logic       unused_bus_s;

  assign op_d_s = bus.IR[15:12];
  assign op_e_s = bus.IR_Exec[15:12];
  assign unused_bus_s = ^{bus.NZP, bus.IMem_dout};

  // Next FSM state and next stage-valid bits.
  always_comb begin
    state_nxt_s = state_r;
    f_v_nxt_s   = f_v_r;
    d_v_nxt_s   = d_v_r;
    e_v_nxt_s   = e_v_r;
    w_v_nxt_s   = w_v_r;
    case (state_r)
      RUN: begin
        if (e_v_r && ((op_e_s == OP_LD) || (op_e_s == OP_LDR))) begin
          state_nxt_s = MEM_RD;
        end else if (e_v_r && ((op_e_s == OP_ST) || (op_e_s == OP_STR))) begin
          state_nxt_s = MEM_WR;
        end else if (e_v_r && ((op_e_s == OP_LDI) || (op_e_s == OP_STI))) begin
          state_nxt_s = MEM_IND;
        end else begin
          f_v_nxt_s = 1'b1;
          d_v_nxt_s = f_v_r & bus.complete_instr;
          e_v_nxt_s = d_v_r;
          w_v_nxt_s = e_v_r & ~no_writeback(op_e_s);
          if (d_v_r && ((op_d_s == OP_BR) || (op_d_s == OP_JMP))) begin
            state_nxt_s = CTRL;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      CTRL: begin
        // Flush decode and execute so the refill ramps up like startup.
        f_v_nxt_s   = 1'b1;
        d_v_nxt_s   = 1'b0;
        e_v_nxt_s   = 1'b0;
        w_v_nxt_s   = e_v_r & ~no_writeback(op_e_s);
        state_nxt_s = RUN;
      end
      MEM_IND: begin
        if (bus.complete_data) begin
          state_nxt_s = (op_e_s == OP_LDI) ? MEM_RD : MEM_WR;
        end else begin
          state_nxt_s = MEM_IND;
        end
      end
      MEM_RD, MEM_WR: begin
        if (bus.complete_data) begin
          f_v_nxt_s   = 1'b1;
          d_v_nxt_s   = f_v_r & bus.complete_instr;
          e_v_nxt_s   = d_v_r;
          w_v_nxt_s   = (state_r == MEM_RD);
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Decode the upcoming state into enable and memory-state values.
  always_comb begin
    en_nxt_s = 5'b00000;
    ms_nxt_s = MS_IDLE;
    case (state_nxt_s)
      RUN: begin
        en_nxt_s = {f_v_nxt_s, f_v_nxt_s, d_v_nxt_s, e_v_nxt_s, w_v_nxt_s};
        ms_nxt_s = MS_IDLE;
      end
      CTRL: begin
        en_nxt_s = {1'b1, 1'b0, 1'b0, 1'b1, w_v_nxt_s};
        ms_nxt_s = MS_IDLE;
      end
      MEM_IND: begin
        en_nxt_s = 5'b00000;
        ms_nxt_s = MS_IND;
      end
      MEM_RD: begin
        en_nxt_s = 5'b00000;
        ms_nxt_s = MS_RD;
      end
      MEM_WR: begin
        en_nxt_s = 5'b00000;
        ms_nxt_s = MS_WR;
      end
      default: begin
        en_nxt_s = 5'b00000;
        ms_nxt_s = MS_IDLE;
      end
    endcase
  end

  // FSM, valid registers and registered stage enables / memory state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= RUN;
      f_v_r       <= 1'b1;
      d_v_r       <= 1'b0;
      e_v_r       <= 1'b0;
      w_v_r       <= 1'b0;
      en_r        <= 5'b11000;
      mem_state_r <= MS_IDLE;
    end else begin
      state_r     <= state_nxt_s;
      f_v_r       <= f_v_nxt_s;
      d_v_r       <= d_v_nxt_s;
      e_v_r       <= e_v_nxt_s;
      w_v_r       <= w_v_nxt_s;
      en_r        <= en_nxt_s;
      mem_state_r <= ms_nxt_s;
    end
  end

  // Branch decision while the transfer instruction sits in execute.
  always_comb begin
    br_taken_s = 1'b0;
    if (state_r == CTRL) begin
      if (op_e_s == OP_JMP) begin
        br_taken_s = 1'b1;
      end else begin
        br_taken_s = |(bus.IR_Exec[11:9] & bus.psr);
      end
    end else begin
      br_taken_s = 1'b0;
    end
  end

  lc3_bypass_unit u_bypass (
    .enable       (e_v_r & d_v_r & (state_r == RUN)),
    .ir           (bus.IR),
    .ir_exec      (bus.IR_Exec),
    .bypass_alu_1 (bus.bypass_alu_1),
    .bypass_alu_2 (bus.bypass_alu_2),
    .bypass_mem_1 (bus.bypass_mem_1),
    .bypass_mem_2 (bus.bypass_mem_2)
  );

  assign bus.enable_updatePC  = en_r[4];
  assign bus.enable_fetch     = en_r[3];
  assign bus.enable_decode    = en_r[2];
  assign bus.enable_execute   = en_r[1];
  assign bus.enable_writeback = en_r[0];
  assign bus.mem_state        = mem_state_r;
  assign bus.br_taken         = br_taken_s;

endmodule

// File: tb/tb_lc3_control_unit.sv
// Randomized and directed bench for lc3_control_unit with a behavioural
// pipeline model; every cycle the DUT outputs are compared to the model.
module tb_lc3_control_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle_no = 0;

  lc3_control_unit_if bus();

  lc3_control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: which stages hold a live instruction, and what the
  // controller is doing ("RUN", "CTRL", "IND", "RD", "WR").
  bit    v[4];
  string mode;

  function automatic bit writes_back(input logic [15:0] instr);
    logic [3:0] o;
    o = instr[15:12];
    return !(o inside {4'h0, 4'h3, 4'h7, 4'hB, 4'hC});
  endfunction

  task automatic model_edge();
    logic [3:0] xo;
    logic [3:0] dop;
    bit nv[4];
    xo  = bus.IR_Exec[15:12];
    dop = bus.IR[15:12];
    nv[0] = 1'b1;
    nv[1] = v[0] && bus.complete_instr;
    nv[2] = v[1];
    nv[3] = v[2] && writes_back(bus.IR_Exec);
    if (!reset) begin
      v = '{1'b1, 1'b0, 1'b0, 1'b0};
      mode = "RUN";
    end else if (mode == "RUN") begin
      if (v[2] && (xo inside {4'h2, 4'h6})) mode = "RD";
      else if (v[2] && (xo inside {4'h3, 4'h7})) mode = "WR";
      else if (v[2] && (xo inside {4'hA, 4'hB})) mode = "IND";
      else begin
        mode = (v[1] && (dop == 4'h0 || dop == 4'hC)) ? "CTRL" : "RUN";
        v = nv;
      end
    end else if (mode == "CTRL") begin
      v = nv;
      v[1] = 1'b0;
      v[2] = 1'b0;
      mode = "RUN";
    end else if (mode == "IND") begin
      if (bus.complete_data) mode = (xo == 4'hA) ? "RD" : "WR";
    end else begin
      if (bus.complete_data) begin
        nv[3] = (mode == "RD");
        v = nv;
        mode = "RUN";
      end
    end
  endtask

  // Expected {updatePC, fetch, decode, execute, writeback, br_taken,
  //           alu_1, alu_2, mem_1, mem_2, mem_state[1:0]}.
  function automatic logic [11:0] expected_outputs();
    logic [4:0] en;
    logic [1:0] ms;
    logic       br;
    logic [3:0] bp;
    logic [3:0] xo;
    logic [3:0] dop;
    logic       s1, s2;
    xo  = bus.IR_Exec[15:12];
    dop = bus.IR[15:12];
    en = 5'b00000;
    ms = 2'd3;
    br = 1'b0;
    bp = 4'b0000;
    if (mode == "RUN") en = {v[0], v[0], v[1], v[2], v[3]};
    else if (mode == "CTRL") en = {1'b1, 1'b0, 1'b0, 1'b1, v[3]};
    if (mode == "RD") ms = 2'd0;
    else if (mode == "IND") ms = 2'd1;
    else if (mode == "WR") ms = 2'd2;
    if (mode == "CTRL") br = (xo == 4'hC) || ((bus.IR_Exec[11:9] & bus.psr) != 3'b000);
    if (mode == "RUN" && v[1] && v[2]) begin
      s1 = (bus.IR_Exec[11:9] == bus.IR[8:6]);
      s2 = (dop inside {4'h1, 4'h5}) && !bus.IR[5] && (bus.IR_Exec[11:9] == bus.IR[2:0]);
      if (xo inside {4'h1, 4'h5, 4'h9}) bp = {s1, s2, 2'b00};
      if (xo inside {4'h2, 4'h6, 4'hA}) bp = {2'b00, s1, s2};
    end
    return {en, br, bp, ms};
  endfunction

  function automatic logic [11:0] actual_outputs();
    return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
            bus.enable_execute, bus.enable_writeback, bus.br_taken,
            bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1,
            bus.bypass_mem_2, bus.mem_state};
  endfunction

  task automatic compare();
    logic [11:0] a;
    logic [11:0] e;
    a = actual_outputs();
    e = expected_outputs();
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL cycle_check cycle %0d mode %s: got %03h expected %03h",
               cycle_no, mode, a, e);
    end
  endtask

  task automatic check_lit(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle_no, act, exp);
    end
  endtask

  // One clock: check current outputs, advance DUT and model, return at negedge.
  task automatic step();
    #1 compare();
    @(posedge clock);
    model_edge();
    cycle_no++;
    @(negedge clock);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  ops [12];
    logic [15:0] r;
    ops = '{4'h0, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'hA, 4'h3, 4'h7, 4'hB, 4'hC, 4'hE};
    r = 16'($urandom);
    r[15:12] = ops[$urandom_range(0, 11)];
    r[11:9]  = {1'b0, 2'($urandom_range(0, 3))};
    r[8:6]   = {1'b0, 2'($urandom_range(0, 3))};
    r[2:0]   = {1'b0, 2'($urandom_range(0, 3))};
    return r;
  endfunction

  initial begin
    bus.complete_data  = 1'b0;
    bus.complete_instr = 1'b1;
    bus.IR             = 16'h18C3;
    bus.IR_Exec        = 16'h16C1;
    bus.NZP            = 3'b000;
    bus.psr            = 3'b010;
    bus.IMem_dout      = 16'h0000;
    reset              = 1'b0;
    mode               = "RUN";
    v                  = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Establish a known state before comparing anything.
    @(posedge clock);
    model_edge();
    @(negedge clock);
    step();
    check_lit("rst_updatepc", 2'(bus.enable_updatePC), 2'd1);
    check_lit("rst_decode", 2'(bus.enable_decode), 2'd0);
    check_lit("rst_mem_state", bus.mem_state, 2'd3);

    // Startup ramp.
    reset = 1'b1;
    step();
    check_lit("ramp_decode_e1", 2'(bus.enable_decode), 2'd1);
    check_lit("ramp_execute_e1", 2'(bus.enable_execute), 2'd0);
    step();
    check_lit("ramp_execute_e2", 2'(bus.enable_execute), 2'd1);
    check_lit("bypass_alu_1", 2'(bus.bypass_alu_1), 2'd1);
    check_lit("bypass_alu_2", 2'(bus.bypass_alu_2), 2'd1);
    step();
    check_lit("ramp_writeback_e3", 2'(bus.enable_writeback), 2'd1);
    check_lit("ramp_mem_state", bus.mem_state, 2'd3);

    // Load producer forwarding, then the LDR enters MEM_RD.
    bus.IR_Exec = 16'h66C0;
    #1;
    check_lit("bypass_mem_1", 2'(bus.bypass_mem_1), 2'd1);
    check_lit("bypass_mem_2", 2'(bus.bypass_mem_2), 2'd1);
    check_lit("bypass_alu_1_off", 2'(bus.bypass_alu_1), 2'd0);
    step();
    check_lit("ldr_mem_state", bus.mem_state, 2'd0);
    check_lit("ldr_stall_fetch", 2'(bus.enable_fetch), 2'd0);

    // Reset in the middle of MEM_RD, then a stray complete_data pulse.
    reset = 1'b0;
    step();
    check_lit("midrd_rst_mem_state", bus.mem_state, 2'd3);
    check_lit("midrd_rst_fetch", 2'(bus.enable_fetch), 2'd1);
    reset = 1'b1;
    bus.complete_data = 1'b1;
    bus.IR_Exec = 16'h16C1;
    step();
    check_lit("stray_cd_mem_state", bus.mem_state, 2'd3);
    bus.complete_data = 1'b0;
    step();

    // LDI: indirect read, then read, then writeback.
    bus.IR_Exec = 16'hA6C0;
    step();
    check_lit("ldi_ind", bus.mem_state, 2'd1);
    check_lit("ldi_stall_exec", 2'(bus.enable_execute), 2'd0);
    for (int i = 0; i < 3; i++) step();
    check_lit("ldi_ind_hold", bus.mem_state, 2'd1);
    bus.complete_data = 1'b1;
    step();
    check_lit("ldi_rd", bus.mem_state, 2'd0);
    bus.complete_data = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_lit("ldi_rd_hold", bus.mem_state, 2'd0);
    bus.complete_data = 1'b1;
    bus.IR_Exec = 16'h16C1;
    step();
    check_lit("ldi_exit_idle", bus.mem_state, 2'd3);
    check_lit("ldi_exit_wb", 2'(bus.enable_writeback), 2'd1);

    // STR: single-cycle write.
    bus.IR_Exec = 16'h7000;
    step();
    check_lit("str_wr", bus.mem_state, 2'd2);
    bus.IR_Exec = 16'h16C1;
    step();
    check_lit("str_exit_idle", bus.mem_state, 2'd3);
    check_lit("str_exit_wb", 2'(bus.enable_writeback), 2'd0);
    bus.complete_data = 1'b0;

    // BR nz taken (psr Z) and not taken (psr P).
    for (int k = 0; k < 2; k++) begin
      bus.psr = (k == 0) ? 3'b010 : 3'b001;
      bus.IR = 16'h0C05;
      step();
      bus.IR_Exec = 16'h0C05;
      bus.IR = 16'h18C3;
      #1;
      check_lit("br_taken", 2'(bus.br_taken), (k == 0) ? 2'd1 : 2'd0);
      check_lit("ctrl_fetch", 2'(bus.enable_fetch), 2'd0);
      check_lit("ctrl_execute", 2'(bus.enable_execute), 2'd1);
      step();
      check_lit("ctrl_exit_fetch", 2'(bus.enable_fetch), 2'd1);
      check_lit("ctrl_exit_decode", 2'(bus.enable_decode), 2'd0);
      bus.IR_Exec = 16'h16C1;
      step();
      check_lit("refill_decode", 2'(bus.enable_decode), 2'd1);
    end

    // Randomized traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      reset              = ($urandom_range(0, 63) != 0);
      bus.complete_instr = ($urandom_range(0, 3) != 0);
      bus.complete_data  = ($urandom_range(0, 2) == 0);
      bus.IR             = rand_instr();
      bus.IR_Exec        = rand_instr();
      bus.psr            = 3'($urandom_range(0, 7));
      bus.NZP            = 3'($urandom_range(0, 7));
      bus.IMem_dout      = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
